// File: rtl/io_pad_arbiter.sv
// Shares one bidirectional pad among NREQ fabric drivers: round-robin ownership with a
// per-owner hold limit, an undriven turnaround gap, registered pad drive and a 2-flop input sync.
module io_pad_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dout,
    output logic [NREQ-1:0] grant,
    output logic            pad_out,
    output logic            pad_oe,
    input  logic            pad_in,
    output logic            pin_in
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               pad_oe_q, pad_oe_d;
    logic               pad_out_q, pad_out_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [2:0]         turn_q, turn_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic               sync1_q, sync2_q;

    logic [IDX_W-1:0]   winner;
    logic [3:0]         turn_next;
    logic               arb_en;
    logic               others_pending;
    logic               release_own;

    // First set request strictly after the previous owner, wrapping modulo NREQ.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                     input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && r[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                w     = idx[IDX_W-1:0];
            end
        end
        return w;
    endfunction

    assign winner         = pick_winner(req, last_owner_q);
    assign turn_next      = {1'b0, turn_q} + 4'd1;
    assign others_pending = |(req & ~grant_q);
    assign release_own    = !req[last_owner_q] ||
                            ((MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD)) && others_pending);

    // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        pad_oe_d     = pad_oe_q;
        pad_out_d    = pad_out_q;
        hold_d       = hold_q;
        turn_d       = turn_q;
        last_owner_d = last_owner_q;
        arb_en       = 1'b0;

        unique case (state_q)
            IDLE: arb_en = 1'b1;
            OWN: begin
                if (release_own) begin
                    state_d   = (TURNAROUND == 0) ? IDLE : TURN;
                    grant_d   = '0;
                    pad_oe_d  = 1'b0;
                    pad_out_d = 1'b0;
                    turn_d    = '0;
                end else begin
                    pad_out_d = dout[last_owner_q];
                    if (MAX_HOLD != 0 && hold_q != HOLD_W'(MAX_HOLD))
                        hold_d = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                if (turn_next == 4'(TURNAROUND)) arb_en = 1'b1;
                else                             turn_d = turn_next[2:0];
            end
            default: state_d = IDLE;
        endcase

        // The last turnaround cycle behaves exactly like IDLE so the gap is not stretched.
        if (arb_en) begin
            state_d   = IDLE;
            grant_d   = '0;
            pad_oe_d  = 1'b0;
            pad_out_d = 1'b0;
            if (|req) begin
                state_d      = OWN;
                grant_d      = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                pad_oe_d     = 1'b1;
                pad_out_d    = dout[winner];
                hold_d       = HOLD_W'(1);
                last_owner_d = winner;
            end
        end
    end

    // NOTE: reset is synchronous and active-low; sequential state uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            pad_oe_q     <= 1'b0;
            pad_out_q    <= 1'b0;
            hold_q       <= '0;
            turn_q       <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            pad_oe_q     <= pad_oe_d;
            pad_out_q    <= pad_out_d;
            hold_q       <= hold_d;
            turn_q       <= turn_d;
            last_owner_q <= last_owner_d;
            sync1_q      <= pad_in;
            sync2_q      <= sync1_q;
        end
    end

    assign grant   = grant_q;
    assign pad_oe  = pad_oe_q;
    assign pad_out = pad_out_q;
    assign pin_in  = sync2_q;

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Scoreboard bench for io_pad_arbiter: each driven cycle queues the hand-computed outputs
// expected after the next edge; a monitor pops and compares them just after every posedge.
module tb_io_pad_arbiter;

    typedef struct {
        logic [3:0] grant;
        logic       oe;
        logic       out;
        logic       pin;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] dout = '0;
    logic       pad_in = 1'b0;
    logic [3:0] grant;
    logic       pad_out, pad_oe, pin_in;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_tag  = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    io_pad_arbiter #(.NREQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut (
        .clk(clk), .rst(rst), .req(req), .dout(dout), .grant(grant),
        .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in), .pin_in(pin_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input logic [7:0] got,
                         input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s (test %0d, t=%0t): got %0h expected %0h", name, tag, $time, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the following posedge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic p,
                       input logic [3:0] eg, input logic eo);
        exp_t x;
        @(negedge clk);
        rst = r; req = rq; dout = d; pad_in = p;
        if (!r) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = p;
        end
        x.grant = eg; x.oe = |eg; x.out = eo; x.pin = m_s2; x.tag = cur_tag;
        exp_q.push_back(x);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant",   e.tag, 8'(grant),   8'(e.grant));
            check("pad_oe",  e.tag, 8'(pad_oe),  8'(e.oe));
            check("pad_out", e.tag, 8'(pad_out), 8'(e.out));
            check("pin_in",  e.tag, 8'(pin_in),  8'(e.pin));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pat;
        int          n;
        pat = 20'hA3C5A;
        n   = 0;

        // 1: reset held with all requests and pad_in high
        cur_tag = 1;
        repeat (3) cyc(1'b0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0);

        // 2: single requester, data follows dout one cycle later
        cur_tag = 2;
        cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // 3: all requesting, hold limit 4 then one-cycle gap, round robin 0,1,2,3,0
        cur_tag = 3;
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(1'b1, 4'hF, 4'b0101, pat[n], 4'(1 << k), (k % 2) == 0);
                n++;
            end
            cyc(1'b1, 4'hF, 4'b0101, pat[n], 4'b0000, 1'b0);
            n++;
        end
        cyc(1'b1, 4'hF, 4'b0101, 1'b1, 4'b0001, 1'b1);

        // 4: lone requester 2 is never preempted; data toggles every cycle
        cur_tag = 4;
        cyc(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 4'b0100, i[0] ? 4'b0100 : 4'b0000, i[1], 4'b0100, i[0]);

        // 5: reset mid-ownership, restart from requester 0, early release hands over to 3
        cur_tag = 5;
        cyc(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'hF,    4'b0000, 1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b1001, 4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(1'b1, 4'b1000, 4'b0001, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // 6: pad_in rising edge crosses the synchronizer while ownership changes
        cur_tag = 6;
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 0, 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
